// File: rtl/display_scaler.sv
`timescale 1ns/1ps
// display_scaler
//
// Takes 2-bit source pixels from the PPU line renderer into a ping-pong line
// buffer. On the HDMI raster it maps each pixel through a BGP-style palette
// and replicates it SCALE times horizontally and vertically. Everything runs
// in the clk_hdmi domain.
//
// Optional build macro: DISPLAY_SCANLINE_EN
//   When defined, the last repeat line of every source row is dimmed to half
//   intensity per channel. The backdrop is not dimmed.
//
// Ports
//   clk_hdmi      pixel clock
//   rst           asynchronous active-high reset
//   hdmi_de       active-video enable; raster counters advance only while high
//   hdmi_hsync_n  line sync (active-low); clears the column counters
//   hdmi_vsync_n  frame sync (active-low); clears all raster counters
//   wr_valid      source pixel valid
//   wr_ready      fill buffer can accept a pixel
//   wr_pixel      2-bit colour index
//   wr_last       last pixel of the source line
//   bgp           palette; shade of index i is bgp[2i+1:2i]
//   lcd_on        0 forces shade 0 over the image area
//   line_req      one-cycle pulse: fill buffer freed, send next line
//   src_row       source row currently displayed
//   underrun      sticky; a row ended while the fill buffer was not full
//   rgb_out       registered pixel colour, one cycle behind the raster position
module display_scaler #(
    parameter int          SRC_W        = 160,
    parameter int          SRC_H        = 144,
    parameter int          SCALE        = 3,
    parameter logic [23:0] BACKDROP_RGB = 24'h236467
) (
    input  logic        clk_hdmi,
    input  logic        rst,
    input  logic        hdmi_de,
    input  logic        hdmi_hsync_n,
    input  logic        hdmi_vsync_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_pixel,
    input  logic        wr_last,
    input  logic [7:0]  bgp,
    input  logic        lcd_on,
    output logic        line_req,
    output logic [7:0]  src_row,
    output logic        underrun,
    output logic [23:0] rgb_out
);

    // Counter widths carry one extra bit so the saturation values
    // (SRC_W, SRC_H) are representable.
    localparam int CW = $clog2(SRC_W) + 1;
    localparam int RW = $clog2(SRC_H) + 1;
    localparam int SW = $clog2(SCALE) + 1;
    localparam int AW = (SRC_W > 1) ? $clog2(SRC_W) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(SRC_W - 1);
    localparam logic [CW-1:0] COL_END  = CW'(SRC_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(SRC_H - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(SRC_H);
    localparam logic [SW-1:0] REP_LAST = SW'(SCALE - 1);

    function automatic logic [23:0] shade_rgb(input logic [1:0] s);
        logic [23:0] c;
        case (s)
            2'd0:    c = 24'hC0B0B0;
            2'd1:    c = 24'h908080;
            2'd2:    c = 24'h605050;
            default: c = 24'h302020;
        endcase
        return c;
    endfunction

    function automatic logic [23:0] scan_dim(input logic [23:0] c);
        return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
    endfunction

    // Line buffers: disp_sel=0 displays A and fills B, disp_sel=1 the reverse.
    logic [1:0] buf_a [SRC_W];
    logic [1:0] buf_b [SRC_W];

    logic          disp_sel_q,   disp_sel_d;
    logic          fill_full_q,  fill_full_d;
    logic [CW-1:0] wr_ptr_q,     wr_ptr_d;
    logic          prime_pend_q, prime_pend_d;
    logic          vsync_n_q;
    logic          line_req_q,   line_req_d;
    logic          underrun_q,   underrun_d;
    logic [CW-1:0] col_q,        col_d;
    logic [SW-1:0] col_rep_q,    col_rep_d;
    logic [RW-1:0] row_q,        row_d;
    logic [SW-1:0] row_rep_q,    row_rep_d;
    logic [23:0]   rgb_q,        rgb_d;

    logic          accept;
    logic          fills_now;
    logic          swap_pt;
    logic          prime_go;
    logic          do_swap;
    logic          in_img;
    logic [1:0]    rd_idx;
    logic [1:0]    shade;
    logic [23:0]   pix;

    // Fill side and buffer-role control
    always_comb begin
        disp_sel_d   = disp_sel_q;
        fill_full_d  = fill_full_q;
        wr_ptr_d     = wr_ptr_q;
        prime_pend_d = prime_pend_q;
        line_req_d   = 1'b0;
        underrun_d   = underrun_q;
        do_swap      = 1'b0;

        accept    = wr_valid && !fill_full_q;
        // The beat landing in the last slot fills the buffer even without wr_last.
        fills_now = accept && (wr_last || (wr_ptr_q == COL_LAST));
        // Last pixel of the last repeat of any row that has a successor row.
        swap_pt   = hdmi_de && hdmi_hsync_n && hdmi_vsync_n &&
                    (col_q == COL_LAST) && (col_rep_q == REP_LAST) &&
                    (row_rep_q == REP_LAST) && (row_q < ROW_LAST);
        prime_go  = !hdmi_vsync_n && prime_pend_q && fill_full_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + CW'(1);
        end
        if (fills_now) begin
            fill_full_d = 1'b1;
        end

        if (!hdmi_vsync_n && vsync_n_q) begin
            prime_pend_d = 1'b1;
        end

        if (swap_pt) begin
            // A line completing on this very cycle still counts as ready.
            if (fill_full_q || fills_now) begin
                do_swap = 1'b1;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (prime_go) begin
            do_swap      = 1'b1;
            prime_pend_d = 1'b0;
        end

        if (do_swap) begin
            disp_sel_d  = !disp_sel_q;
            fill_full_d = 1'b0;
            wr_ptr_d    = '0;
            line_req_d  = 1'b1;
        end
    end

    // Raster position counters
    always_comb begin
        col_d     = col_q;
        col_rep_d = col_rep_q;
        row_d     = row_q;
        row_rep_d = row_rep_q;

        if (!hdmi_vsync_n) begin
            col_d     = '0;
            col_rep_d = '0;
            row_d     = '0;
            row_rep_d = '0;
        end else if (!hdmi_hsync_n) begin
            col_d     = '0;
            col_rep_d = '0;
        end else if (hdmi_de) begin
            if (col_rep_q == REP_LAST) begin
                col_rep_d = '0;
                if (col_q != COL_END) begin
                    col_d = col_q + CW'(1);
                end
                if (col_q == COL_LAST) begin
                    if (row_rep_q == REP_LAST) begin
                        row_rep_d = '0;
                        if (row_q != ROW_END) begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        row_rep_d = row_rep_q + SW'(1);
                    end
                end
            end else begin
                col_rep_d = col_rep_q + SW'(1);
            end
        end
    end

    // Colour lookup for the current raster position
    always_comb begin
        in_img = (row_q < ROW_END) && (col_q < COL_END);
        rd_idx = disp_sel_q ? buf_b[col_q[AW-1:0]] : buf_a[col_q[AW-1:0]];
        shade  = bgp[{rd_idx, 1'b0} +: 2];
        pix    = lcd_on ? shade_rgb(shade) : shade_rgb(2'd0);
`ifdef DISPLAY_SCANLINE_EN
        if (row_rep_q == REP_LAST) begin
            pix = scan_dim(pix);
        end
`endif
        rgb_d  = in_img ? pix : BACKDROP_RGB;
    end

    // Buffer writes go to whichever buffer is currently filling.
    always_ff @(posedge clk_hdmi) begin
        if (accept) begin
            if (disp_sel_q) begin
                buf_a[wr_ptr_q[AW-1:0]] <= wr_pixel;
            end else begin
                buf_b[wr_ptr_q[AW-1:0]] <= wr_pixel;
            end
        end
    end

    always_ff @(posedge clk_hdmi or posedge rst) begin
        if (rst) begin
            disp_sel_q   <= 1'b0;
            fill_full_q  <= 1'b0;
            wr_ptr_q     <= '0;
            prime_pend_q <= 1'b1;
            vsync_n_q    <= 1'b1;
            line_req_q   <= 1'b0;
            underrun_q   <= 1'b0;
            col_q        <= '0;
            col_rep_q    <= '0;
            row_q        <= '0;
            row_rep_q    <= '0;
            rgb_q        <= '0;
        end else begin
            disp_sel_q   <= disp_sel_d;
            fill_full_q  <= fill_full_d;
            wr_ptr_q     <= wr_ptr_d;
            prime_pend_q <= prime_pend_d;
            vsync_n_q    <= hdmi_vsync_n;
            line_req_q   <= line_req_d;
            underrun_q   <= underrun_d;
            col_q        <= col_d;
            col_rep_q    <= col_rep_d;
            row_q        <= row_d;
            row_rep_q    <= row_rep_d;
            rgb_q        <= rgb_d;
        end
    end

    assign wr_ready = !fill_full_q;
    assign line_req = line_req_q;
    assign underrun = underrun_q;
    assign src_row  = 8'(row_q);
    assign rgb_out  = rgb_q;

endmodule

// File: tb/tb_display_scaler.sv
`timescale 1ns/1ps
// Bench for display_scaler. Uses a short frame (SRC_H=6) so rows beyond the
// image are reachable; SRC_W and SCALE keep their defaults.
module tb_display_scaler;

    localparam int          SRC_W   = 160;
    localparam int          SRC_H   = 6;
    localparam int          SCALE   = 3;
    localparam logic [23:0] BD      = 24'h236467;
    localparam int          IMG_PX  = SRC_W * SCALE;
    localparam int          LINE_DE = IMG_PX + 10;
`ifdef DISPLAY_SCANLINE_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic        clk_hdmi = 1'b0;
    logic        rst;
    logic        hdmi_de, hdmi_hsync_n, hdmi_vsync_n;
    logic        wr_valid, wr_ready, wr_last;
    logic [1:0]  wr_pixel;
    logic [7:0]  bgp;
    logic        lcd_on;
    logic        line_req, underrun;
    logic [7:0]  src_row;
    logic [23:0] rgb_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          ps;        // first line cycle with wr_valid high
        int          n;         // number of cycles wr_valid is high
        logic [1:0]  pix;
        logic        last;      // assert wr_last on the final valid cycle
        logic [7:0]  pal;
        logic        lcd;
        logic [23:0] img;       // expected colour over the 480 image pixels
        int          lr_k;      // line cycle of the line_req pulse, -1 none
        int          rdy_k;     // first line cycle with wr_ready high, -1 none
        int          row_after;
        logic        ur_after;
    } line_t;

    line_t tbl [22];

    display_scaler #(.SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE), .BACKDROP_RGB(BD)) dut (
        .clk_hdmi     (clk_hdmi),
        .rst          (rst),
        .hdmi_de      (hdmi_de),
        .hdmi_hsync_n (hdmi_hsync_n),
        .hdmi_vsync_n (hdmi_vsync_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_pixel     (wr_pixel),
        .wr_last      (wr_last),
        .bgp          (bgp),
        .lcd_on       (lcd_on),
        .line_req     (line_req),
        .src_row      (src_row),
        .underrun     (underrun),
        .rgb_out      (rgb_out)
    );

    always #5 clk_hdmi = ~clk_hdmi;

    initial begin
        #2ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_hdmi);
        #1;
    endtask

    function automatic logic [23:0] dim(input logic [23:0] c, input int rep);
        logic [23:0] r;
        r = c;
        if (SCAN && rep == SCALE - 1 && c != BD)
            r = {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
        return r;
    endfunction

    // Push n beats with the raster idle; wr_last on the final beat.
    task automatic push(input logic [1:0] pix, input int n, output int beats, output int lr_n);
        int   cyc;
        logic acc;
        cyc   = 0;
        beats = 0;
        lr_n  = 0;
        while (beats < n && cyc < 4 * SRC_W) begin
            wr_valid = 1'b1;
            wr_pixel = pix;
            wr_last  = (beats == n - 1);
            acc      = wr_ready;
            step();
            if (acc) beats++;
            if (line_req === 1'b1) lr_n++;
            cyc++;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (line_req === 1'b1) lr_n++;
        end
    endtask

    // One HDMI line: a single hsync cycle, then LINE_DE cycles of active video.
    task automatic run_line(input int li, input int rep);
        line_t       t;
        logic [23:0] want;
        logic [23:0] first_img, first_bd;
        int          bad_img, bad_bd, lr_n, lr_k, rdy_k;
        t         = tbl[li];
        want      = dim(t.img, rep);
        bad_img   = 0;
        bad_bd    = 0;
        lr_n      = 0;
        lr_k      = -1;
        rdy_k     = -1;
        first_img = '0;
        first_bd  = '0;
        bgp       = t.pal;
        lcd_on    = t.lcd;
        hdmi_hsync_n = 1'b0;
        hdmi_de      = 1'b0;
        wr_valid     = 1'b0;
        step();
        hdmi_hsync_n = 1'b1;
        hdmi_de      = 1'b1;
        for (int k = 0; k < LINE_DE; k++) begin
            wr_valid = (k >= t.ps) && (k < t.ps + t.n);
            wr_pixel = t.pix;
            wr_last  = t.last && (k == t.ps + t.n - 1);
            step();
            if (k < IMG_PX) begin
                if (rgb_out !== want) begin
                    if (bad_img == 0) first_img = rgb_out;
                    bad_img++;
                end
            end else if (rgb_out !== BD) begin
                if (bad_bd == 0) first_bd = rgb_out;
                bad_bd++;
            end
            if (line_req === 1'b1) begin
                lr_n++;
                if (lr_k < 0) lr_k = k;
            end
            if (wr_ready === 1'b1 && rdy_k < 0) rdy_k = k;
        end
        hdmi_de  = 1'b0;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        step();
        checks++;
        if (bad_img != 0) begin
            failures++;
            $display("FAIL L%0d_image bad_pixels=%0d actual=%h required=%h", li, bad_img, first_img, want);
        end
        checks++;
        if (bad_bd != 0) begin
            failures++;
            $display("FAIL L%0d_backdrop bad_pixels=%0d actual=%h required=%h", li, bad_bd, first_bd, BD);
        end
        check($sformatf("L%0d_line_req_count", li), lr_n, (t.lr_k >= 0) ? 1 : 0);
        check($sformatf("L%0d_line_req_cycle", li), lr_k, t.lr_k);
        check($sformatf("L%0d_wr_ready_rise", li), rdy_k, t.rdy_k);
        check($sformatf("L%0d_src_row", li), src_row, t.row_after);
        check($sformatf("L%0d_underrun", li), underrun, t.ur_after);
    endtask

    initial begin
        int beats, lr_n;

        //        ps   n    pix  last  pal    lcd   img          lr_k rdy_k row ur
        // Row 0: row-1 data already buffered, producer held off by wr_ready.
        tbl[0]  = '{0,   480, 2'd3, 1'b0, 8'hE4, 1'b1, 24'h908080, -1,  -1,  0, 1'b0};
        tbl[1]  = '{0,   480, 2'd3, 1'b0, 8'hE4, 1'b1, 24'h908080, -1,  -1,  0, 1'b0};
        tbl[2]  = '{0,   480, 2'd3, 1'b0, 8'hE4, 1'b1, 24'h908080, 479, 479, 1, 1'b0};
        // Row 1: next line's wr_last lands exactly on the swap point.
        tbl[3]  = '{0,   0,   2'd0, 1'b0, 8'hE4, 1'b1, 24'h605050, -1,  0,   1, 1'b0};
        tbl[4]  = '{0,   0,   2'd0, 1'b0, 8'hE4, 1'b1, 24'h605050, -1,  0,   1, 1'b0};
        tbl[5]  = '{320, 160, 2'd0, 1'b1, 8'hE4, 1'b1, 24'h605050, 479, 0,   2, 1'b0};
        // Row 2: no data for row 3 -> underrun.
        tbl[6]  = '{0,   0,   2'd0, 1'b0, 8'h00, 1'b1, 24'hC0B0B0, -1,  0,   2, 1'b0};
        tbl[7]  = '{0,   0,   2'd0, 1'b0, 8'h00, 1'b1, 24'hC0B0B0, -1,  0,   2, 1'b0};
        tbl[8]  = '{0,   0,   2'd0, 1'b0, 8'h00, 1'b1, 24'hC0B0B0, -1,  0,   3, 1'b1};
        // Rows 3-4 repeat row 2's index-0 pixels; palette / lcd_on sweep.
        tbl[9]  = '{0,   0,   2'd0, 1'b0, 8'h1B, 1'b1, 24'h302020, -1,  0,   3, 1'b1};
        tbl[10] = '{0,   0,   2'd0, 1'b0, 8'h1B, 1'b0, 24'hC0B0B0, -1,  0,   3, 1'b1};
        tbl[11] = '{0,   0,   2'd0, 1'b0, 8'h01, 1'b1, 24'h908080, -1,  0,   4, 1'b1};
        tbl[12] = '{0,   0,   2'd0, 1'b0, 8'h02, 1'b1, 24'h605050, -1,  0,   4, 1'b1};
        tbl[13] = '{0,   0,   2'd0, 1'b0, 8'hFF, 1'b0, 24'hC0B0B0, -1,  0,   4, 1'b1};
        tbl[14] = '{320, 160, 2'd3, 1'b1, 8'hE4, 1'b1, 24'hC0B0B0, 479, 0,   5, 1'b1};
        // Row 5 is the last row: a full fill buffer must not swap at its end.
        tbl[15] = '{0,   0,   2'd0, 1'b0, 8'hE4, 1'b1, 24'h302020, -1,  0,   5, 1'b1};
        tbl[16] = '{0,   160, 2'd1, 1'b1, 8'h40, 1'b1, 24'h908080, -1,  0,   5, 1'b1};
        tbl[17] = '{0,   0,   2'd0, 1'b0, 8'hE4, 1'b1, 24'h302020, -1,  -1,  6, 1'b1};
        // Row 6 (>= SRC_H): backdrop only, row saturates.
        tbl[18] = '{0,   0,   2'd0, 1'b0, 8'hE4, 1'b1, BD,         -1,  -1,  6, 1'b1};
        tbl[19] = '{0,   0,   2'd0, 1'b0, 8'hE4, 1'b1, BD,         -1,  -1,  6, 1'b1};
        tbl[20] = '{0,   0,   2'd0, 1'b0, 8'hE4, 1'b1, BD,         -1,  -1,  6, 1'b1};
        // Second frame, row 0: line delivered before vsync (index 1).
        tbl[21] = '{0,   0,   2'd0, 1'b0, 8'hE4, 1'b1, 24'h908080, -1,  0,   0, 1'b1};

        rst          = 1'b1;
        hdmi_de      = 1'b0;
        hdmi_hsync_n = 1'b1;
        hdmi_vsync_n = 1'b1;
        wr_valid     = 1'b0;
        wr_pixel     = 2'd0;
        wr_last      = 1'b0;
        bgp          = 8'hE4;
        lcd_on       = 1'b1;
        step();
        step();
        check("rst_rgb_out",  rgb_out,  24'h0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_line_req", line_req, 0);
        check("rst_underrun", underrun, 0);
        check("rst_src_row",  src_row,  0);
        rst = 1'b0;
        step();

        // Frame prime: first line during vsync swaps in once.
        hdmi_vsync_n = 1'b0;
        step();
        push(2'd1, SRC_W, beats, lr_n);
        check("prime_beats",    beats, SRC_W);
        check("prime_line_req", lr_n, 1);
        check("prime_wr_ready", wr_ready, 1);
        push(2'd2, SRC_W, beats, lr_n);
        check("row1_beats",     beats, SRC_W);
        check("row1_line_req",  lr_n, 0);
        check("row1_wr_ready",  wr_ready, 0);
        hdmi_vsync_n = 1'b1;
        step();

        for (int li = 0; li < 21; li++) run_line(li, li % SCALE);

        // Second frame: fill buffer already full when vsync falls.
        hdmi_vsync_n = 1'b0;
        lr_n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (line_req === 1'b1) lr_n++;
        end
        check("vs2_line_req", lr_n, 1);
        check("vs2_src_row",  src_row, 0);
        check("vs2_wr_ready", wr_ready, 1);
        hdmi_vsync_n = 1'b1;
        step();
        run_line(21, 0);

        // Fill a line with the raster idle (no swap point), then reset mid-line.
        push(2'd2, SRC_W, beats, lr_n);
        check("pre_rst_line_req", lr_n, 0);
        check("pre_rst_wr_ready", wr_ready, 0);
        hdmi_hsync_n = 1'b0;
        step();
        hdmi_hsync_n = 1'b1;
        hdmi_de      = 1'b1;
        for (int i = 0; i < 50; i++) step();
        rst = 1'b1;
        #2;
        check("midrst_rgb_out",  rgb_out,  24'h0);
        check("midrst_wr_ready", wr_ready, 1);
        check("midrst_underrun", underrun, 0);
        check("midrst_src_row",  src_row,  0);
        check("midrst_line_req", line_req, 0);
        hdmi_de = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("post_rst_wr_ready", wr_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scaler.md
# display_scaler

Parametrised successor to the GameBoy display path. It accepts a stream of 2-bit source pixels from the renderer into a ping-pong line buffer. It maps each pixel through a BGP-style palette and replicates it `SCALE` times horizontally and vertically on the HDMI raster. It sits between the PPU line renderer and the HDMI timing generator, entirely in the `clk_hdmi` domain. It adds back-pressure handshaking, line-request pacing and underrun detection.

## Interface
- `SRC_W`, default 160: source pixels per line.
- `SRC_H`, default 144: source lines per frame.
- `SCALE`, default 3: integer replication factor, 1..4.
- `BACKDROP_RGB`, default 24'h236467: colour outside the scaled image.
- `clk_hdmi`  in  1  pixel clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `hdmi_de`  in  1  active-video enable.
- `hdmi_hsync_n`  in  1  line sync, active-low.
- `hdmi_vsync_n`  in  1  frame sync, active-low.
- `wr_valid`  in  1  source pixel valid.
- `wr_ready`  out  1  fill buffer can accept a pixel.
- `wr_pixel`  in  2  colour index.
- `wr_last`  in  1  last pixel of the source line.
- `bgp`  in  8  palette; shade of index i is `bgp[2i+1:2i]`.
- `lcd_on`  in  1  LCD enable; 0 forces shade 0 over the image area.
- `line_req`  out  1  one-cycle pulse: fill buffer freed, send the next line.
- `src_row`  out  8  source row currently displayed.
- `underrun`  out  1  sticky; row end reached with the fill buffer not full.
- `rgb_out`  out  24  registered pixel colour.

## Operation
- Two buffers A and B, each `SRC_W` x 2 bits. Role bit `disp_sel` selects the display buffer; the other buffer is the fill buffer.
- Fill side:
  - A beat is accepted when `wr_valid && wr_ready`. The pixel is written at `wr_ptr`, then `wr_ptr` increments.
  - The fill buffer becomes full on an accepted `wr_last`, or when `wr_ptr` reaches `SRC_W`.
  - On an early `wr_last`, unwritten entries keep their old contents.
  - `wr_ready` equals `!fill_full`.
- Raster counters:
  - `col_rep` counts 0..SCALE-1; at SCALE-1 it wraps and `col` increments, saturating at `SRC_W`.
  - At the end of the line (`col==SRC_W-1`, `col_rep==SCALE-1`), `row_rep` advances 0..SCALE-1. At its wrap, `row` increments, saturating at `SRC_H`.
  - Counters advance only while `hdmi_de` is high.
  - `hdmi_hsync_n` low clears `col` and `col_rep`.
  - `hdmi_vsync_n` low clears all four counters.
- Swap rules:
  - Swap point is the last pixel of the last repeat of rows 0..SRC_H-2. If the fill buffer is full there: toggle `disp_sel`, clear `fill_full` and `wr_ptr`, and pulse `line_req` on the next cycle.
  - If the fill buffer is not full at the swap point: no swap, the old line repeats, and `underrun` is set.
  - An accepted `wr_last` in the same cycle as the swap point counts as full, and the swap happens.
- Frame prime:
  - Entering vsync-low sets `prime_pend`.
  - While vsync is low, `prime_pend` is set and the fill buffer is full: perform one swap, clear `prime_pend`, pulse `line_req`.
  - Row 0 therefore comes from the first line delivered during or before vsync.
- Colour mapping:
  - Pixels with `row<SRC_H` and `col<SRC_W` use shade `bgp[2*idx+1:2*idx]`. Shades 0..3 map to C0B0B0, 908080, 605050, 302020.
  - When `lcd_on`=0, these pixels use C0B0B0.
  - All other pixels use `BACKDROP_RGB`.
- `src_row` = `row`. Every arithmetic width is sized from `$clog2` of its parameter plus 1 so that saturation values are representable.

## Timing
- Reset values:
  - `rgb_out`=0, `wr_ready`=1, `line_req`=0, `underrun`=0, `src_row`=0.
  - `disp_sel`=0, `fill_full`=0, `wr_ptr`=0, `prime_pend`=1.
  - All raster counters 0.
- `rgb_out` lags the counter position by 1 cycle; the buffer read is combinational and the output register follows it.
- Handshake:
  - The write takes effect on the accepting edge.
  - `wr_ready` drops on the cycle after the full condition.
  - `wr_ready` rises on the cycle after the swap.
- `line_req` is exactly one cycle wide, with at most one pulse per swap.
- `underrun` clears only on `rst`.
- Reset asserted mid-line discards both buffers' status. On release, the producer must wait for `line_req` or observe `wr_ready` high.

## Configuration
- `DISPLAY_SCANLINE_EN`:
  - Defined: on `row_rep==SCALE-1`, each 8-bit channel of in-image pixels is halved (`>>1`). Backdrop pixels are unaffected.
  - Undefined: all repeat lines are identical.

## Test plan
- Reset, then push 160 pixels of index 1 with `bgp`=8'hE4 during vsync -> one swap, `line_req` pulse; row 0 shows 480 pixels of 908080, then `BACKDROP_RGB`.
- Hold `wr_valid` high with the fill buffer full -> `wr_ready`=0, no pointer change; `wr_ready` rises 1 cycle after the swap at the end of row 0.
- Withhold row 1 data -> `underrun`=1, row 1 repeats row 0's pixels, no `line_req`.
- Accept `wr_last` on the exact swap-point cycle -> swap occurs, `underrun` stays 0.
- `lcd_on`=0 with `bgp`=8'h1B -> every in-image pixel is C0B0B0; pixels at col>=160 or row>=144 are 236467.
- With `DISPLAY_SCANLINE_EN` and index 0, `bgp`=8'h00 -> the third repeat line is 605858; the other repeat lines are C0B0B0.
